// File: rtl/dmi_access_ctrl_pkg.sv
// Shared DMI transaction types: request/response structs, DTM op codes and
// the sticky DMI error encoding reported back through the DR capture value.
package dm;

  localparam int unsigned DbgAddressBits = 7;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2
  } dtm_op_e;

  typedef enum logic [1:0] {
    DMI_NO_ERROR  = 2'h0,
    DMI_RESERVED  = 2'h1,
    DMI_OP_FAILED = 2'h2,
    DMI_BUSY      = 2'h3
  } dmi_error_e;

  typedef struct packed {
    logic [DbgAddressBits-1:0] addr;
    dtm_op_e                   op;
    logic [31:0]               data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

endpackage

// File: rtl/dmi_access_ctrl.sv
// JTAG-side DMI access controller: turns DMI Update-DR into one CDC handshake and
// tracks sticky busy/failed status. Define DMI_RESP_ERR_EN to flag non-zero responses.
module dmi_access_ctrl
  import dm::*;
#(
  parameter int unsigned AbitsW = 7,
  parameter int unsigned DrW    = AbitsW + 34
) (
  input  logic           tck_i,
  input  logic           trst_ni,
  input  logic           dmi_access_i,
  input  logic           capture_i,
  input  logic           update_i,
  input  logic [DrW-1:0] dr_i,
  output logic [DrW-1:0] dr_o,
  input  logic           dmireset_i,
  input  logic           dmihardreset_i,
  output dmi_req_t       dmi_req_o,
  output logic           dmi_req_valid_o,
  input  logic           dmi_req_ready_i,
  input  dmi_resp_t      dmi_resp_i,
  input  logic           dmi_resp_valid_i,
  output logic           dmi_resp_ready_o
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_READ       = 3'd1,
    ST_WAIT_READ  = 3'd2,
    ST_WRITE      = 3'd3,
    ST_WAIT_WRITE = 3'd4
  } state_e;

  state_e            state_r, state_next_s;
  dmi_error_e        error_r, error_next_s;
  logic [AbitsW-1:0] addr_r;
  logic [31:0]       data_r;
  logic              latch_s;
  logic              busy_s;
  logic              resp_done_s;
  logic              resp_err_s;

  assign busy_s      = (update_i | capture_i) & dmi_access_i & (state_r != ST_IDLE);
  assign resp_done_s = dmi_resp_valid_i &
                       ((state_r == ST_WAIT_READ) | (state_r == ST_WAIT_WRITE));

`ifdef DMI_RESP_ERR_EN
  assign resp_err_s = resp_done_s & (dmi_resp_i.resp != 2'd0);
`else
  logic unused_resp_s;
  assign unused_resp_s = ^dmi_resp_i.resp;
  assign resp_err_s    = 1'b0;
`endif

  // Next-state and handshake outputs; request payload comes from registers only.
  always_comb begin
    state_next_s     = state_r;
    latch_s          = 1'b0;
    dmi_req_valid_o  = 1'b0;
    dmi_resp_ready_o = 1'b0;
    dmi_req_o        = '0;
    dmi_req_o.addr   = addr_r;
    dmi_req_o.data   = data_r;
    dmi_req_o.op     = DTM_NOP;
    case (state_r)
      ST_IDLE: begin
        if (update_i && dmi_access_i && (error_r == DMI_NO_ERROR)) begin
          latch_s = 1'b1;
          case (dr_i[1:0])
            DTM_READ:  state_next_s = ST_READ;
            DTM_WRITE: state_next_s = ST_WRITE;
            default:   state_next_s = ST_IDLE;
          endcase
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_READ: begin
        dmi_req_valid_o = 1'b1;
        dmi_req_o.op    = DTM_READ;
        if (dmi_req_ready_i) begin
          state_next_s = ST_WAIT_READ;
        end else begin
          state_next_s = ST_READ;
        end
      end
      ST_WRITE: begin
        dmi_req_valid_o = 1'b1;
        dmi_req_o.op    = DTM_WRITE;
        if (dmi_req_ready_i) begin
          state_next_s = ST_WAIT_WRITE;
        end else begin
          state_next_s = ST_WRITE;
        end
      end
      ST_WAIT_READ, ST_WAIT_WRITE: begin
        dmi_resp_ready_o = 1'b1;
        if (dmi_resp_valid_i) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = state_r;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Sticky error: explicit clears beat busy, busy beats a failed response.
  always_comb begin
    error_next_s = error_r;
    if (dmireset_i || dmihardreset_i) begin
      error_next_s = DMI_NO_ERROR;
    end else if (busy_s) begin
      error_next_s = DMI_BUSY;
    end else if (resp_err_s) begin
      error_next_s = DMI_OP_FAILED;
    end else begin
      error_next_s = error_r;
    end
  end

  // FSM and error registers.
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_r <= ST_IDLE;
      error_r <= DMI_NO_ERROR;
    end else begin
      state_r <= state_next_s;
      error_r <= error_next_s;
    end
  end

  // Address/data holding registers; a read response still lands after a hard reset.
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      addr_r <= '0;
      data_r <= 32'h0;
    end else begin
      if (dmihardreset_i) begin
        addr_r <= '0;
      end else if (latch_s) begin
        addr_r <= dr_i[DrW-1:34];
      end else begin
        addr_r <= addr_r;
      end
      if (resp_done_s && (state_r == ST_WAIT_READ)) begin
        data_r <= dmi_resp_i.data;
      end else if (dmihardreset_i) begin
        data_r <= 32'h0;
      end else if (latch_s) begin
        data_r <= dr_i[33:2];
      end else begin
        data_r <= data_r;
      end
    end
  end

  assign dr_o = {addr_r, data_r, ((state_r != ST_IDLE) ? 2'd3 : 2'(error_r))};

endmodule

// File: tb/tb_dmi_access_ctrl.sv
// Directed self-checking bench for dmi_access_ctrl with hand-computed vectors.
module tb_dmi_access_ctrl;
  import dm::*;

  logic        tck;
  logic        trst_n;
  logic        dmi_access;
  logic        capture;
  logic        update;
  logic [40:0] dr_in;
  logic [40:0] dr_out;
  logic        dmireset;
  logic        dmihardreset;
  dmi_req_t    dmi_req;
  logic        req_valid;
  logic        req_ready;
  dmi_resp_t   dmi_resp;
  logic        resp_valid;
  logic        resp_ready;

  int vec_cnt = 0;
  int err_cnt = 0;

  dmi_access_ctrl dut (
    .tck_i            (tck),
    .trst_ni          (trst_n),
    .dmi_access_i     (dmi_access),
    .capture_i        (capture),
    .update_i         (update),
    .dr_i             (dr_in),
    .dr_o             (dr_out),
    .dmireset_i       (dmireset),
    .dmihardreset_i   (dmihardreset),
    .dmi_req_o        (dmi_req),
    .dmi_req_valid_o  (req_valid),
    .dmi_req_ready_i  (req_ready),
    .dmi_resp_i       (dmi_resp),
    .dmi_resp_valid_i (resp_valid),
    .dmi_resp_ready_o (resp_ready)
  );

  initial begin
    tck = 1'b0;
    forever #5 tck = ~tck;
  end

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic do_update(input logic [40:0] dr);
    dr_in  = dr;
    update = 1'b1;
    tick();
    update = 1'b0;
  endtask

  task automatic do_capture();
    capture = 1'b1;
    tick();
    capture = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data, input logic [1:0] resp);
    dmi_resp.data = data;
    dmi_resp.resp = resp;
    resp_valid    = 1'b1;
    tick();
    resp_valid    = 1'b0;
    dmi_resp      = '0;
  endtask

  initial begin
    trst_n       = 1'b0;
    dmi_access   = 1'b1;
    capture      = 1'b0;
    update       = 1'b0;
    dr_in        = 41'h0;
    dmireset     = 1'b0;
    dmihardreset = 1'b0;
    req_ready    = 1'b1;
    dmi_resp     = '0;
    resp_valid   = 1'b0;

    #3;
    check_vec("reset_dr", 64'(dr_out), 64'h0);
    check_vec("reset_req", 64'({dmi_req, req_valid, resp_ready}), 64'h0);
    #19 trst_n = 1'b1;
    tick();

    // Write with ready tied high
    do_update({7'h10, 32'h8000_0001, 2'd2});
    @(negedge tck);
    check_vec("wr_valid", 64'(req_valid), 64'h1);
    check_vec("wr_req", 64'(dmi_req), 64'({7'h10, 2'd2, 32'h8000_0001}));
    tick();
    check_vec("wr_valid_one_cycle", 64'({req_valid, resp_ready}), 64'h1);
    respond(32'h0, 2'd0);
    do_capture();
    check_vec("wr_capture", 64'(dr_out), 64'({7'h10, 32'h8000_0001, 2'd0}));

    // Read returning DEADBEEF
    do_update({7'h11, 32'h0, 2'd1});
    @(negedge tck);
    check_vec("rd_req", 64'({req_valid, dmi_req}), 64'({1'b1, 7'h11, 2'd1, 32'h0}));
    tick();
    check_vec("rd_wait_dr", 64'(dr_out), 64'({7'h11, 32'h0, 2'd3}));
    respond(32'hDEAD_BEEF, 2'd0);
    check_vec("rd_capture", 64'(dr_out), 64'({7'h11, 32'hDEAD_BEEF, 2'd0}));

    // Busy: ready held low, capture then update mid-transaction
    req_ready = 1'b0;
    do_update({7'h12, 32'hA5A5_A5A5, 2'd2});
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        capture = 1'b1;
      end else if (i == 6) begin
        capture = 1'b0;
        update  = 1'b1;
        dr_in   = {7'h13, 32'h1111_1111, 2'd2};
      end else begin
        update  = 1'b0;
      end
      tick();
    end
    update = 1'b0;
    check_vec("busy_hold", 64'({req_valid, dmi_req}), 64'({1'b1, 7'h12, 2'd2, 32'hA5A5_A5A5}));
    check_vec("busy_status", 64'(dr_out[1:0]), 64'h3);
    req_ready = 1'b1;
    tick();
    respond(32'h0, 2'd0);
    check_vec("busy_sticky", 64'(dr_out), 64'({7'h12, 32'hA5A5_A5A5, 2'd3}));
    do_update({7'h14, 32'h0, 2'd1});
    check_vec("busy_ignored", 64'(req_valid), 64'h0);
    dmireset = 1'b1;
    tick();
    dmireset = 1'b0;
    check_vec("dmireset_clear", 64'(dr_out[1:0]), 64'h0);
    do_update({7'h14, 32'h0, 2'd1});
    check_vec("reenabled", 64'({req_valid, dmi_req.addr}), 64'({1'b1, 7'h14}));

    // Hard reset while waiting for read data, with a busy error pending
    tick();
    do_capture();
    dmihardreset = 1'b1;
    tick();
    dmihardreset = 1'b0;
    check_vec("hr_wait", 64'({req_valid, resp_ready, dr_out}), 64'({1'b0, 1'b1, 7'h0, 32'h0, 2'd3}));
    respond(32'h1234_5678, 2'd0);
    check_vec("hr_late_data", 64'(dr_out), 64'({7'h0, 32'h1234_5678, 2'd0}));

    // Write answered with resp=2
    do_update({7'h15, 32'h0000_CAFE, 2'd2});
    tick();
    respond(32'h0, 2'd2);
`ifdef DMI_RESP_ERR_EN
    check_vec("resp_err", 64'(dr_out), 64'({7'h15, 32'h0000_CAFE, 2'd2}));
    dmireset = 1'b1;
    tick();
    dmireset = 1'b0;
`else
    check_vec("resp_err", 64'(dr_out), 64'({7'h15, 32'h0000_CAFE, 2'd0}));
`endif

    // NOP latches fields but issues no request
    do_update({7'h2A, 32'h0F0F_0F0F, 2'd0});
    check_vec("nop", 64'({req_valid, dr_out}), 64'({1'b0, 7'h2A, 32'h0F0F_0F0F, 2'd0}));

    // Async reset while request valid
    req_ready = 1'b0;
    do_update({7'h16, 32'h5555_AAAA, 2'd2});
    check_vec("pre_rst_valid", 64'(req_valid), 64'h1);
    #2 trst_n = 1'b0;
    #1;
    check_vec("async_rst", 64'({dmi_req, req_valid, resp_ready, dr_out}), 64'h0);
    #3 trst_n = 1'b1;
    req_ready = 1'b1;
    tick();
    check_vec("post_rst_idle", 64'({req_valid, resp_ready, dr_out[1:0]}), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
